// File: rtl/ib_ram_page_loader.sv
// ib_ram_page_loader: packs BANK_INTERLEAVE_NUM incoming IB-LUT pages into one
// IB-RAM row word and writes it with an active-low strobe at incrementing page
// addresses. The bank field is always 0, placed in the MSBs (type 0) or the
// LSBs (type 1) of the SRAM address.
// Optional feature: define IB_RAM_LOADER_WRAP_ERR_EN to turn a page-address
// wrap into an error (write suppressed, err_o set). Without it the address
// wraps modulo PAGE_NUM and err_o is tied low.
//
// state | meaning
// IDLE  | waiting for start_i
// FILL  | accepting pages into the pack register
// WRITE | single-cycle write strobe of the packed row
// DONE  | one-cycle completion pulse
module ib_ram_page_loader #(
  parameter int BANK_INTERLEAVE_TYPE = 0,
  parameter int BANK_INTERLEAVE_NUM  = 2,
  parameter int ADDR_WIDTH           = 6,
  parameter int BANK_ADDR_WIDTH      = $clog2(BANK_INTERLEAVE_NUM),
  parameter int PAGE_ADDR_WIDTH      = ADDR_WIDTH - BANK_ADDR_WIDTH,
  parameter int PAGE_SIZE            = 4,
  parameter int WDATA_SIZE           = PAGE_SIZE * BANK_INTERLEAVE_NUM,
  parameter int PAGE_NUM             = 32
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [PAGE_ADDR_WIDTH-1:0] base_page_i,
  input  logic [PAGE_ADDR_WIDTH-1:0] row_cnt_i,
  input  logic [PAGE_SIZE-1:0]       page_data_i,
  input  logic                       page_valid_i,
  output logic                       page_ready_o,
  output logic [WDATA_SIZE-1:0]      wdata_o,
  output logic [ADDR_WIDTH-1:0]      access_addr_o,
  output logic                       wen_n_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  localparam logic [BANK_ADDR_WIDTH-1:0] LANE_LAST  = BANK_ADDR_WIDTH'(BANK_INTERLEAVE_NUM - 1);
  localparam logic [BANK_ADDR_WIDTH-1:0] BANK_ZERO  = '0;
  localparam logic [PAGE_ADDR_WIDTH:0]   PAGE_NUM_L = (PAGE_ADDR_WIDTH + 1)'(PAGE_NUM);

  state_t state, state_next;

  logic [PAGE_ADDR_WIDTH-1:0] base_q, cnt_q, row_q;
  logic [BANK_ADDR_WIDTH-1:0] lane_q;
  logic [WDATA_SIZE-1:0]      pack_q, pack_next;
  logic                       accept, last_lane, overflow;
  logic [PAGE_ADDR_WIDTH:0]   sum;
  logic [PAGE_ADDR_WIDTH-1:0] page_addr;
  logic [ADDR_WIDTH-1:0]      addr_next;

  // page_ready_o is a registered copy of (state == FILL), so it doubles as the
  // FILL qualifier for the handshake.
  assign accept    = page_valid_i & page_ready_o;
  assign last_lane = (lane_q == LANE_LAST);

  // base and row are both below PAGE_NUM, so one conditional subtract wraps.
  assign sum       = {1'b0, base_q} + {1'b0, row_q};
  assign page_addr = (sum >= PAGE_NUM_L) ? PAGE_ADDR_WIDTH'(sum - PAGE_NUM_L)
                                         : sum[PAGE_ADDR_WIDTH-1:0];
  assign addr_next = (BANK_INTERLEAVE_TYPE == 0) ? {BANK_ZERO, page_addr}
                                                 : {page_addr, BANK_ZERO};

`ifdef IB_RAM_LOADER_WRAP_ERR_EN
  assign overflow = (sum >= PAGE_NUM_L);
`else
  assign overflow = 1'b0;
`endif

  // Pack register with the page being accepted this cycle merged in, so the
  // row word is complete on the WRITE-entry edge.
  always_comb begin
    pack_next = pack_q;
    if (accept) pack_next[lane_q*PAGE_SIZE +: PAGE_SIZE] = page_data_i;
  end

  // State register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_i) state_next = S_FILL;
      S_FILL:  if (accept && last_lane) state_next = overflow ? S_DONE : S_WRITE;
      S_WRITE: state_next = (row_q == cnt_q) ? S_DONE : S_FILL;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Load parameters, lane/row counters and the pack register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      row_q  <= '0;
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      if (state == S_IDLE && start_i) begin
        base_q <= base_page_i;
        cnt_q  <= row_cnt_i;
        row_q  <= '0;
        lane_q <= '0;
        pack_q <= '0;
      end else if (accept) begin
        pack_q <= pack_next;
        lane_q <= last_lane ? '0 : lane_q + 1'b1;
      end else if (state == S_WRITE && row_q != cnt_q) begin
        row_q  <= row_q + 1'b1;
        lane_q <= '0;
      end
    end
  end

  // Registered outputs, derived from the upcoming state; write data and
  // address only change on WRITE entry and hold afterwards.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      page_ready_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      wen_n_o       <= 1'b1;
      wdata_o       <= '0;
      access_addr_o <= '0;
    end else begin
      page_ready_o <= (state_next == S_FILL);
      busy_o       <= (state_next != S_IDLE);
      done_o       <= (state_next == S_DONE);
      wen_n_o      <= (state_next != S_WRITE);
      if (state == S_FILL && state_next == S_WRITE) begin
        wdata_o       <= pack_next;
        access_addr_o <= addr_next;
      end
    end
  end

`ifdef IB_RAM_LOADER_WRAP_ERR_EN
  // Sticky wrap error, cleared by the next accepted start.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                                    err_o <= 1'b0;
    else if (state == S_IDLE && start_i)        err_o <= 1'b0;
    else if (state == S_FILL && accept && last_lane && overflow) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ib_ram_page_loader.sv
// Self-checking bench for ib_ram_page_loader: expected row writes go into a
// scoreboard queue when a load is started and are popped on each write strobe.
module tb_ib_ram_page_loader;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [4:0] base_page_i = '0;
  logic [4:0] row_cnt_i = '0;
  logic [3:0] page_data_i = '0;
  logic       page_valid_i = 1'b0;

  logic       page_ready_o, wen_n_o, busy_o, done_o, err_o;
  logic [7:0] wdata_o;
  logic [5:0] access_addr_o;

  logic       ready_1, wen_n_1, busy_1, done_1, err_1;
  logic [7:0] wdata_1;
  logic [5:0] addr_1;

  int   checks = 0;
  int   failures = 0;
  int   strobes = 0;
  logic prev_wen = 1'b1;
  exp_t exp_q[$];

  always #5 sys_clk = ~sys_clk;

  ib_ram_page_loader #(.BANK_INTERLEAVE_TYPE(0)) u_dut (
    .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .base_page_i(base_page_i),
    .row_cnt_i(row_cnt_i), .page_data_i(page_data_i), .page_valid_i(page_valid_i),
    .page_ready_o(page_ready_o), .wdata_o(wdata_o), .access_addr_o(access_addr_o),
    .wen_n_o(wen_n_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  ib_ram_page_loader #(.BANK_INTERLEAVE_TYPE(1)) u_dut1 (
    .sys_clk(sys_clk), .rst(rst), .start_i(start_i), .base_page_i(base_page_i),
    .row_cnt_i(row_cnt_i), .page_data_i(page_data_i), .page_valid_i(page_valid_i),
    .page_ready_o(ready_1), .wdata_o(wdata_1), .access_addr_o(addr_1),
    .wen_n_o(wen_n_1), .busy_o(busy_1), .done_o(done_1), .err_o(err_1)
  );

  // Scoreboard: every strobe of the type-0 instance pops one expected write.
  always @(posedge sys_clk) begin
    #1;
    if (!rst && wen_n_o === 1'b0) begin
      exp_t e;
      strobes++;
      checks++;
      if (prev_wen === 1'b0) begin
        failures++;
        $display("FAIL strobe_width: wen_n_o low on consecutive cycles, required one cycle");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", access_addr_o, wdata_o);
      end else begin
        e = exp_q.pop_front();
        if (access_addr_o !== e.addr || wdata_o !== e.data) begin
          failures++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                   access_addr_o, wdata_o, e.addr, e.data);
        end
      end
    end
    prev_wen = wen_n_o;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_i = 1'b0;
    page_valid_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_load(input logic [4:0] base, input logic [4:0] cnt);
    start_i = 1'b1;
    base_page_i = base;
    row_cnt_i = cnt;
    tick();
    start_i = 1'b0;
  endtask

  // Holds valid with data until the loader takes it; leaves valid high so
  // consecutive calls stream back-to-back.
  task automatic send_page(input logic [3:0] d);
    bit got = 0;
    page_valid_i = 1'b1;
    page_data_i = d;
    for (int i = 0; i < 50 && !got; i++) begin
      got = page_ready_o;
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL send_page: page %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = done_o;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s: done_o not seen within 40 cycles", name);
    end
  endtask

  task automatic check_drained(input string name, input int strobes_before, input int n);
    checks++;
    if (strobes - strobes_before != n || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s: strobes=%0d pending=%0d, required strobes=%0d pending=0",
               name, strobes - strobes_before, exp_q.size(), n);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (page_ready_o !== 1'b0 || wen_n_o !== 1'b1 || wdata_o !== 8'h00 ||
        access_addr_o !== 6'h00 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s: ready=%b wen_n=%b wdata=%h addr=%h busy=%b done=%b err=%b, required 0 1 00 00 0 0 0",
               name, page_ready_o, wen_n_o, wdata_o, access_addr_o, busy_o, done_o, err_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_reset_values("reset_state");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_row();
    int s0;
    do_reset();
    s0 = strobes;
    exp_q.push_back('{addr: 6'h03, data: 8'h5A});
    start_load(5'd3, 5'd0);
    checks++;
    if (page_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL start_latency: ready=%b busy=%b one cycle after start, required 1 1", page_ready_o, busy_o);
    end
    send_page(4'hA);
    send_page(4'h5);
    page_valid_i = 1'b0;
    checks++;
    if (wen_n_o !== 1'b0 || page_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL write_cycle: wen_n=%b ready=%b, required 0 0", wen_n_o, page_ready_o);
    end
    checks++;
    if (wen_n_1 !== 1'b0 || addr_1 !== 6'h06 || wdata_1 !== 8'h5A) begin
      failures++;
      $display("FAIL type1_write: wen_n=%b addr=%h data=%h, required 0 06 5a", wen_n_1, addr_1, wdata_1);
    end
    tick();
    checks++;
    if (done_o !== 1'b1 || wen_n_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL done_latency: done=%b wen_n=%b busy=%b, required 1 1 1", done_o, wen_n_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || wdata_o !== 8'h5A || access_addr_o !== 6'h03) begin
      failures++;
      $display("FAIL after_done: done=%b busy=%b wdata=%h addr=%h, required 0 0 5a 03",
               done_o, busy_o, wdata_o, access_addr_o);
    end
    check_drained("single_row_count", s0, 1);
  endtask

  task automatic test_wrap();
    int s0;
    do_reset();
    s0 = strobes;
    exp_q.push_back('{addr: 6'd30, data: 8'h21});
    exp_q.push_back('{addr: 6'd31, data: 8'h43});
`ifndef IB_RAM_LOADER_WRAP_ERR_EN
    exp_q.push_back('{addr: 6'd0, data: 8'h65});
`endif
    start_load(5'd30, 5'd2);
    for (int p = 1; p <= 6; p++) send_page(4'(p));
    page_valid_i = 1'b0;
    wait_done("wrap_done");
`ifdef IB_RAM_LOADER_WRAP_ERR_EN
    check_drained("wrap_count", s0, 2);
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL wrap_err: err_o=%b, required 1", err_o);
    end
    tick();
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL wrap_err_hold: err_o=%b in IDLE, required 1", err_o);
    end
`else
    check_drained("wrap_count", s0, 3);
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_err: err_o=%b, required 0", err_o);
    end
`endif
  endtask

  task automatic test_valid_gaps();
    int s0;
    do_reset();
    s0 = strobes;
    exp_q.push_back('{addr: 6'd5, data: 8'h21});
    start_load(5'd5, 5'd0);
    page_valid_i = 1'b1; page_data_i = 4'h1; tick();
    page_valid_i = 1'b0; page_data_i = 4'hF; tick();
    page_valid_i = 1'b1; page_data_i = 4'h2; tick();
    page_valid_i = 1'b0; page_data_i = 4'hE;
    wait_done("gaps_done");
    check_drained("gaps_count", s0, 1);
  endtask

  task automatic test_reset_mid_fill();
    int s0;
    do_reset();
    s0 = strobes;
    start_load(5'd7, 5'd0);
    send_page(4'h9);
    page_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values("reset_mid_fill");
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back('{addr: 6'd7, data: 8'h43});
    start_load(5'd7, 5'd0);
    send_page(4'h3);
    send_page(4'h4);
    page_valid_i = 1'b0;
    wait_done("restart_done");
    check_drained("restart_count", s0, 1);
  endtask

  task automatic test_start_while_busy();
    int s0;
    do_reset();
    s0 = strobes;
    exp_q.push_back('{addr: 6'd2, data: 8'h87});
    exp_q.push_back('{addr: 6'd3, data: 8'hBA});
    start_load(5'd2, 5'd1);
    send_page(4'h7);
    start_i = 1'b1;
    base_page_i = 5'd9;
    row_cnt_i = 5'd0;
    send_page(4'h8);
    start_i = 1'b0;
    send_page(4'hA);
    send_page(4'hB);
    page_valid_i = 1'b0;
    wait_done("busy_start_done");
    check_drained("busy_start_count", s0, 2);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_wrap();
    test_valid_gaps();
    test_reset_mid_fill();
    test_start_while_busy();
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
